prio_encode_pipe: RTL and testbench
===================================

Name: prio_encode_pipe

Overview:
- Parametrised, registered successor to the 4-to-2 encoder. Encodes a WIDTH-bit request vector into a binary index, with parity, no-request and multi-hot flags.
- Input side uses a valid/ready handshake. Results pass through a 2-entry output buffer, so upstream logic is decoupled from output backpressure.
- Sits between request-generation logic (e.g. counter/compare flags) and downstream consumers on the single system clock.

Parameters:
- WIDTH, 8, request vector width; legal range 2..64.
- MSB_FIRST, 1, priority direction: 1 = highest set bit wins, 0 = lowest set bit wins.
- STRICT, 0, 1 = only exact one-hot inputs encode; multi-hot gives index 0.
- IDX_W (localparam), $clog2(WIDTH), index width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  request vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_data  in  WIDTH  request vector.
- out_valid  out  1  buffered result valid.
- out_ready  in  1  downstream accepts result this cycle.
- out_idx  out  IDX_W  encoded index.
- out_none  out  1  in_data was all zeros.
- out_multi  out  1  more than one bit was set.
- out_parity  out  1  XOR reduction of in_data (even parity bit).
- err_cnt  out  16  multi-hot event count; present only with PENC_ERR_CNT_EN.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset: buffer count=0, rd/wr pointers=0, out_valid=0, out_idx=0, out_none=0, out_multi=0, out_parity=0, err_cnt=0.
- Reset mid-operation: any buffered entries are discarded and no partial result survives.
- Handshake:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count != 2); it is a pure function of the count register, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - Output fields always reflect the head entry and stay stable while out_valid && !out_ready.
- Latency: a vector accepted in cycle N is visible on the outputs in cycle N+1 when the buffer was empty. Otherwise it queues in order.
- Encode function, computed combinationally on in_data and stored with each entry:
  - none = ~|in_data.
  - multi = popcount(in_data) > 1.
  - parity = ^in_data.
  - STRICT=0: idx = position of the highest set bit (MSB_FIRST=1) or the lowest set bit (MSB_FIRST=0).
  - STRICT=1: idx = bit position if exactly one bit is set, else 0.
  - none=1 gives idx=0 in both modes.
- Buffer: 2-entry circular queue; the pointers wrap modulo 2.
  - Push only: count+1. Pop only: count-1.
  - Push and pop in the same cycle (count=1): count unchanged; the new entry becomes head next cycle.
  - Count=2: in_ready=0, so a same-cycle pop does not admit a push; in_ready rises the following cycle.
  - Count=0 with out_ready=1: no pop and no underflow. There is no same-cycle bypass.
- Data ordering: strict FIFO order, no drops, no duplicates.

Optional Feature:
- Macro: PENC_ERR_CNT_EN.
- Defined:
  - err_cnt port exists.
  - 16-bit counter increments on each accepted push with multi=1.
  - Saturates at 16'hFFFF and holds.
  - Cleared only by reset.
- Undefined:
  - err_cnt port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, MSB_FIRST=1, STRICT=0. Reset low 2 cycles, then push 8'b0010_0000 with out_ready=1 -> next cycle out_valid=1, out_idx=5, out_none=0, out_multi=0, out_parity=1.
- Same config, push 8'b1001_0110 -> out_idx=7, out_multi=1, out_parity=0. With MSB_FIRST=0 -> out_idx=1. With STRICT=1 -> out_idx=0, out_multi=1.
- Push 8'h00 -> out_idx=0, out_none=1, out_parity=0, out_multi=0.
- out_ready=0, push 8'h01 then 8'h80 -> in_ready=0 after the second push and output holds idx=0. A third push attempt is not accepted. Raise out_ready -> idx=0 then idx=7 appear in order; in_ready returns 1 the cycle after the first pop.
- count=1, push and pop in the same cycle over 10 consecutive cycles with random vectors -> count stays 1, every result appears exactly once, in order, 1 cycle after its push.
- Reset asserted with 2 entries buffered -> next cycle out_valid=0, in_ready=1, all outputs 0. With PENC_ERR_CNT_EN: after 3 multi-hot pushes err_cnt=3, and reset clears it to 0.

Source files
------------

// File: rtl/prio_encode_pipe.sv
// prio_encode_pipe: registered priority encoder with a 2-entry output buffer.
// Encodes a WIDTH-bit request vector into a binary index plus none/multi/parity
// flags. The result of each accepted vector is queued in a 2-deep circular
// buffer. The outputs always show the head entry.
// Optional feature: define PENC_ERR_CNT_EN to add the err_cnt port. It is a
// saturating 16-bit count of accepted multi-hot vectors.
module prio_encode_pipe #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit STRICT    = 1'b0,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_none,
  output logic             out_multi,
  output logic             out_parity
`ifdef PENC_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int ENT_W = IDX_W + 3;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready depends only on the buffer count, so it has no path
  // from out_ready. out_valid is high while the buffer holds an entry. Output
  // fields stay stable until the head entry is popped.
  logic             push;
  logic             pop;
  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [ENT_W-1:0] mem [2];
  logic [ENT_W-1:0] head;

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_none;
  logic             enc_multi;
  logic             enc_parity;
  logic             seen;

  // Encode in_data.
  // hi_idx is the last set bit scanning upward.
  // lo_idx is the last set bit scanning downward.
  always_comb begin
    hi_idx    = '0;
    lo_idx    = '0;
    seen      = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        hi_idx = IDX_W'(i);
        if (seen) enc_multi = 1'b1;
        seen = 1'b1;
      end
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_data[i]) lo_idx = IDX_W'(i);
    end
    enc_none   = ~|in_data;
    enc_parity = ^in_data;
    // With exactly one bit set, hi_idx and lo_idx are equal.
    // Multi-hot and all-zero vectors both encode to index 0 in strict mode.
    if (STRICT) enc_idx = enc_multi ? '0 : hi_idx;
    else        enc_idx = MSB_FIRST ? hi_idx : lo_idx;
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head       = mem[rd_ptr];
  assign out_idx    = head[ENT_W-1:3];
  assign out_none   = head[2];
  assign out_multi  = head[1];
  assign out_parity = head[0];

  // Buffer storage, pointers and occupancy.
  // Entries are cleared on reset, so the outputs read as zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc_idx, enc_none, enc_multi, enc_parity};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef PENC_ERR_CNT_EN
  // Count accepted multi-hot vectors. The counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)                                       err_cnt <= 16'd0;
    else if (push && enc_multi && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_prio_encode_pipe.sv
// tb_prio_encode_pipe: scoreboard bench for prio_encode_pipe.
// Three instances share one handshake:
//   - MSB-first (main instance)
//   - LSB-first
//   - strict one-hot
// Expected entries are {msb_idx, lsb_idx, strict_idx, none, multi, parity}.
// Optional: define PENC_ERR_CNT_EN to also check err_cnt.
module tb_prio_encode_pipe;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_ready;

  logic          in_ready,  out_valid, out_none, out_multi, out_parity;
  logic [IW-1:0] out_idx;
  logic          l_ready, l_valid, l_none, l_multi, l_parity;
  logic [IW-1:0] l_idx;
  logic          s_ready, s_valid, s_none, s_multi, s_parity;
  logic [IW-1:0] s_idx;
`ifdef PENC_ERR_CNT_EN
  logic [15:0]   err_cnt, l_err_cnt, s_err_cnt;
  int            exp_err;
`endif

  logic [11:0]   exp_q[$];
  int            vectors;
  int            miscompares;

  prio_encode_pipe #(.WIDTH(W), .MSB_FIRST(1'b1), .STRICT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_none(out_none), .out_multi(out_multi),
    .out_parity(out_parity)
`ifdef PENC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  prio_encode_pipe #(.WIDTH(W), .MSB_FIRST(1'b0), .STRICT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_ready),
    .in_data(in_data), .out_valid(l_valid), .out_ready(out_ready),
    .out_idx(l_idx), .out_none(l_none), .out_multi(l_multi),
    .out_parity(l_parity)
`ifdef PENC_ERR_CNT_EN
    , .err_cnt(l_err_cnt)
`endif
  );

  prio_encode_pipe #(.WIDTH(W), .MSB_FIRST(1'b1), .STRICT(1'b1)) u_strict (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ready),
    .in_data(in_data), .out_valid(s_valid), .out_ready(out_ready),
    .out_idx(s_idx), .out_none(s_none), .out_multi(s_multi),
    .out_parity(s_parity)
`ifdef PENC_ERR_CNT_EN
    , .err_cnt(s_err_cnt)
`endif
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder.
  // Scans for the first set bit from each end and counts the ones.
  function automatic logic [11:0] model(input logic [W-1:0] d);
    int hi = 0;
    int lo = 0;
    int st;
    for (int i = W - 1; i >= 0; i--) if (d[i]) begin hi = i; break; end
    for (int i = 0; i < W; i++) if (d[i]) begin lo = i; break; end
    st = ($countones(d) == 1) ? hi : 0;
    return {IW'(hi), IW'(lo), IW'(st), (d == '0), ($countones(d) > 1), ^d};
  endfunction

  // Driver helpers.
  // tick: drive just after the rising edge.
  // mid: observe on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops and compares on each output transfer,
  // and pushes the expected entry on each input transfer.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst_n) begin
      exp_q.delete();
`ifdef PENC_ERR_CNT_EN
      exp_err = 0;
`endif
    end else begin
      check("lsb_valid", 32'(l_valid), 32'(out_valid));
      check("strict_ready", 32'(s_ready), 32'(in_ready));
`ifdef PENC_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(exp_err));
      check("err_cnt_lsb", 32'(l_err_cnt), 32'(exp_err));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_idx",      32'(out_idx),    32'(e[11:9]));
          check("sb_lsb_idx",  32'(l_idx),      32'(e[8:6]));
          check("sb_strict",   32'(s_idx),      32'(e[5:3]));
          check("sb_none",     32'(out_none),   32'(e[2]));
          check("sb_multi",    32'(out_multi),  32'(e[1]));
          check("sb_parity",   32'(out_parity), 32'(e[0]));
          check("sb_flags_l",  32'({l_none, l_multi, l_parity}), 32'(e[2:0]));
          check("sb_flags_s",  32'({s_none, s_multi, s_parity, s_valid, l_ready}),
                               32'({e[2:0], out_valid, in_ready}));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
`ifdef PENC_ERR_CNT_EN
        if ($countones(in_data) > 1 && exp_err < 65535) exp_err++;
`endif
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_flags"}, 32'({out_idx, out_none, out_multi, out_parity}), 32'd0);
  endtask

  initial begin
    logic [W-1:0] specials [6];
    specials = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h96, 8'h20};
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;

    // Reset held low for two edges.
    tick(); tick();
    mid();
    check_zero_outputs("reset");
`ifdef PENC_ERR_CNT_EN
    check("reset_err", 32'(err_cnt), 32'd0);
`endif
    tick();
    rst_n = 1'b1;

    // Single push into an empty buffer; visible one cycle later.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'b0010_0000;
    tick();
    in_valid = 1'b0;
    mid();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_fields", 32'({out_idx, out_none, out_multi, out_parity}), 32'({3'd5, 3'b001}));
    tick();
    mid();
    check("popped_empty", 32'(out_valid), 32'd0);

    // Back-to-back multi-hot and zero vectors.
    tick();
    in_valid = 1'b1;
    in_data  = 8'b1001_0110;
    tick();
    in_data  = 8'h00;
    tick();
    in_valid = 1'b0;
    tick(); tick();

    // Backpressure: fill both entries, then try a third push.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    in_data   = 8'h80;
    tick();
    in_data   = 8'hFF;
    mid();
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_idx", 32'(out_idx), 32'd0);
    tick();
    mid();
    check("hold_ready", 32'(in_ready), 32'd0);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_idx", 32'(out_idx), 32'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mid();
    check("ready_lag", 32'(in_ready), 32'd0);
    tick();
    mid();
    check("ready_back", 32'(in_ready), 32'd1);
    check("second_idx", 32'(out_idx), 32'd7);
    tick();
    mid();
    check("no_third", 32'(out_valid), 32'd0);

    // Steady state at count=1: push and pop together every cycle.
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'($urandom_range(0, 255));
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = W'($urandom_range(0, 255));
      mid();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    mid();
    check("stream_end", 32'(out_valid), 32'd0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 300; k++) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                              : W'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 2) != 0);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick();
    mid();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    // Reset while two entries are buffered.
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hC3;
    tick();
    in_data   = 8'h05;
    tick();
    in_valid  = 1'b0;
    rst_n     = 1'b0;
    mid();
    check("pre_rst_full", 32'({out_valid, in_ready}), 32'b10);
    tick();
    rst_n = 1'b1;
    mid();
    check_zero_outputs("mid_rst");

`ifdef PENC_ERR_CNT_EN
    // Three multi-hot pushes, then reset clears the counter.
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h03;
    tick();
    in_data   = 8'hF0;
    tick();
    in_data   = 8'h81;
    tick();
    in_valid  = 1'b0;
    mid();
    check("err_three", 32'(err_cnt), 32'd3);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mid();
    check("err_cleared", 32'(err_cnt), 32'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
